// File: rtl/rr_arb_bin_if.sv
// Request/grant bundle between requesters, the round-robin arbiter and the downstream decoder.
// The arbiter takes the master side; the consumer of grants takes the slave side.
interface rr_arb_bin_if #(
    parameter int unsigned IN  = 3,
    parameter int unsigned REQ = 1 << IN
);
    logic [REQ-1:0] req;
    logic           grant_valid;
    logic [IN-1:0]  grant_idx;
    logic           grant_ready;

    modport master (
        input  req,
        input  grant_ready,
        output grant_valid,
        output grant_idx
    );

    modport slave (
        output req,
        output grant_ready,
        input  grant_valid,
        input  grant_idx
    );
endinterface

// File: rtl/rr_arb_bin.sv
// Round-robin arbiter with a binary grant index and a valid/ready grant handshake.
// A grant is held until accepted; the search pointer advances past each accepted winner.
module rr_arb_bin #(
    parameter int unsigned IN  = 3,
    parameter int unsigned REQ = 1 << IN,
    parameter logic        ACT = 1'b1
) (
    input logic          clk,
    input logic          reset,
    rr_arb_bin_if.master bus
);

    typedef enum logic [0:0] {StIdle, StHold} state_t;

    state_t         r_state;
    logic           r_valid;
    logic [IN-1:0]  r_idx;
    logic [IN-1:0]  r_ptr;

    logic [REQ-1:0] w_req;
    logic           w_accept;
    logic [IN-1:0]  w_next_ptr;
    logic [IN-1:0]  w_scan_ptr;
    logic [IN-1:0]  w_win;
    logic           w_any;

    // Offset from base, wrapped at REQ (which need not be a power of two).
    function automatic logic [IN-1:0] wrap_idx(input logic [IN-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= REQ) begin
            sum = sum - REQ;
        end
        return IN'(sum);
    endfunction

    assign w_req      = ACT ? bus.req : ~bus.req;
    assign w_accept   = r_valid & bus.grant_ready;
    assign w_next_ptr = (r_idx >= IN'(REQ - 1)) ? '0 : r_idx + IN'(1);
    // On an accept the next winner is searched from the already-advanced pointer.
    assign w_scan_ptr = w_accept ? w_next_ptr : r_ptr;

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int unsigned i = 0; i < REQ; i++) begin
            if (!w_any && w_req[wrap_idx(w_scan_ptr, i)]) begin
                w_any = 1'b1;
                w_win = wrap_idx(w_scan_ptr, i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_state <= StHold;
                        r_valid <= 1'b1;
                        r_idx   <= w_win;
                    end
                end
                StHold: begin
                    if (w_accept) begin
                        r_ptr <= w_next_ptr;
                        if (w_any) begin
                            r_idx <= w_win;
                        end else begin
                            r_state <= StIdle;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant_valid = r_valid;
    assign bus.grant_idx   = r_idx;

endmodule

// File: tb/tb_rr_arb_bin.sv
// Self-checking bench: three arbiters (8 req, 5 req, 8 req active-low) against a queue-free
// behavioural round-robin model, with directed scenarios followed by random traffic.
module tb_rr_arb_bin;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] r8    = '0;
    logic [4:0] r5    = '0;
    logic       rdy   = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    rr_arb_bin_if #(.IN(3), .REQ(8)) bus8  ();
    rr_arb_bin_if #(.IN(3), .REQ(5)) bus5  ();
    rr_arb_bin_if #(.IN(3), .REQ(8)) bus8n ();

    assign bus8.req          = r8;
    assign bus8.grant_ready  = rdy;
    assign bus5.req          = r5;
    assign bus5.grant_ready  = rdy;
    assign bus8n.req         = ~r8;
    assign bus8n.grant_ready = rdy;

    rr_arb_bin #(.IN(3), .REQ(8), .ACT(1'b1)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    rr_arb_bin #(.IN(3), .REQ(5), .ACT(1'b1)) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    rr_arb_bin #(.IN(3), .REQ(8), .ACT(1'b0)) u_dut8n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8n)
    );

    always #5 clk = ~clk;

    logic       dv [3];
    logic [2:0] di [3];
    assign dv[0] = bus8.grant_valid;
    assign di[0] = bus8.grant_idx;
    assign dv[1] = bus5.grant_valid;
    assign di[1] = bus5.grant_idx;
    assign dv[2] = bus8n.grant_valid;
    assign di[2] = bus8n.grant_idx;

    // Reference: a held grant, a pointer, and a modular scan for the first requester.
    int m_valid [3];
    int m_idx   [3];
    int m_ptr   [3];
    int nreq    [3] = '{8, 5, 8};

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0;
            m_idx[k]   = 0;
            m_ptr[k]   = 0;
        end
    endtask

    task automatic model_edge(input int k, input logic [7:0] r);
        int  p;
        int  w;
        bit  acc;
        acc = (m_valid[k] != 0) && rdy;
        p   = m_ptr[k];
        w   = -1;
        if (acc) begin
            p        = (m_idx[k] + 1) % nreq[k];
            m_ptr[k] = p;
        end
        if (m_valid[k] == 0 || acc) begin
            for (int i = 0; i < nreq[k]; i++) begin
                if (w < 0 && r[(p + i) % nreq[k]]) w = (p + i) % nreq[k];
            end
            if (w >= 0) begin
                m_valid[k] = 1;
                m_idx[k]   = w;
            end else begin
                m_valid[k] = 0;
            end
        end
    endtask

    task automatic cycle();
        model_edge(0, r8);
        model_edge(1, {3'b000, r5});
        model_edge(2, r8);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        r8    = '0;
        r5    = '0;
        rdy   = 1'b0;
        model_clear();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dv[k] !== 1'b0 || di[k] !== 3'd0) begin
                n_errors++;
                $display("FAIL reset_init dut%0d: valid=%b idx=%0d, required valid=0 idx=0",
                         k, dv[k], di[k]);
            end
        end
        model_clear();
        r8    = 8'h20;
        rdy   = 1'b0;
        reset = 1'b0;
        cycle();
        n_checks++;
        if (dv[0] !== 1'b1 || di[0] !== 3'd5) begin
            n_errors++;
            $display("FAIL reset_hold5: valid=%b idx=%0d, required valid=1 idx=5", dv[0], di[0]);
        end
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dv[k] !== 1'b0 || di[k] !== 3'd0) begin
                n_errors++;
                $display("FAIL reset_async dut%0d: valid=%b idx=%0d, required valid=0 idx=0",
                         k, dv[k], di[k]);
            end
        end
        r8 = 8'h22;
        #1;
        reset = 1'b0;
        cycle();
        n_checks++;
        if (dv[0] !== 1'b1 || di[0] !== 3'd1) begin
            n_errors++;
            $display("FAIL reset_release: valid=%b idx=%0d, required valid=1 idx=1", dv[0], di[0]);
        end
    endtask

    task automatic test_rotation();
        apply_reset();
        r8  = 8'hFF;
        rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            n_checks++;
            if (dv[0] !== 1'b1 || di[0] !== 3'(i % 8)) begin
                n_errors++;
                $display("FAIL rotation step %0d: valid=%b idx=%0d, required valid=1 idx=%0d",
                         i, dv[0], di[0], i % 8);
            end
        end
    endtask

    task automatic test_hold();
        apply_reset();
        r8  = 8'h10;
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            r8 = 8'h00;
            n_checks++;
            if (dv[0] !== 1'b1 || di[0] !== 3'd4) begin
                n_errors++;
                $display("FAIL hold cycle %0d: valid=%b idx=%0d, required valid=1 idx=4",
                         i, dv[0], di[0]);
            end
        end
        rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if (dv[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL hold_release %0d: valid=%b, required valid=0", i, dv[0]);
            end
        end
    endtask

    task automatic test_fairness();
        apply_reset();
        r8  = 8'h81;
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (dv[0] !== 1'b1 || di[0] !== ((i % 2) ? 3'd7 : 3'd0)) begin
                n_errors++;
                $display("FAIL fairness step %0d: valid=%b idx=%0d, required valid=1 idx=%0d",
                         i, dv[0], di[0], (i % 2) ? 7 : 0);
            end
        end
    endtask

    task automatic test_non_pow2();
        apply_reset();
        r5  = 5'h1F;
        rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_checks++;
            if (dv[1] !== 1'b1 || di[1] !== 3'(i % 5)) begin
                n_errors++;
                $display("FAIL non_pow2 step %0d: valid=%b idx=%0d, required valid=1 idx=%0d",
                         i, dv[1], di[1], i % 5);
            end
        end
    endtask

    task automatic test_single();
        apply_reset();
        r8  = 8'h08;
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (dv[0] !== 1'b1 || di[0] !== 3'd3) begin
                n_errors++;
                $display("FAIL single step %0d: valid=%b idx=%0d, required valid=1 idx=3",
                         i, dv[0], di[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] dec;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            r8  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
            r5  = 5'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            cycle();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (dv[k] !== (m_valid[k] != 0) ||
                    (m_valid[k] != 0 && di[k] !== 3'(m_idx[k]))) begin
                    n_errors++;
                    $display("FAIL random dut%0d cyc %0d: valid=%b idx=%0d, required valid=%0d idx=%0d",
                             k, n, dv[k], di[k], m_valid[k], m_idx[k]);
                end
                if (m_valid[k] != 0) begin
                    dec = 8'd1 << di[k];
                    n_checks++;
                    if (dec !== (8'd1 << m_idx[k]) || int'(di[k]) >= nreq[k]) begin
                        n_errors++;
                        $display("FAIL decode dut%0d cyc %0d: onehot=%b, required %b",
                                 k, n, dec, 8'd1 << m_idx[k]);
                    end
                end
            end
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b1;
                #1;
                model_clear();
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (dv[k] !== 1'b0 || di[k] !== 3'd0) begin
                        n_errors++;
                        $display("FAIL random_reset dut%0d: valid=%b idx=%0d, required 0/0",
                                 k, dv[k], di[k]);
                    end
                end
                #1;
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_rotation();
        test_hold();
        test_fairness();
        test_non_pow2();
        test_single();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arb_bin.md
RR_ARB_BIN -- requirements
Module: rr_arb_bin

Interface
REQ-001: Parameter IN, default 3, SHALL set the grant index width in bits.
REQ-002: Parameter REQ, default 1 << IN, SHALL set the number of requesters; REQ SHALL be greater than or equal to 2 and less than or equal to 1 << IN.
REQ-003: Parameter ACT, default `HIGH, SHALL set the active level of each req bit.
REQ-004: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005: reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006: req  input  REQ  SHALL carry one request bit per requester; a bit is asserted when equal to ACT.
REQ-007: grant_valid  output  1  SHALL be high when grant_idx holds a valid grant.
REQ-008: grant_idx  output  IN  SHALL be the binary index of the granted requester; it is the direct input of the downstream binary-to-one-hot decoder.
REQ-009: grant_ready  input  1  SHALL indicate that the downstream stage accepts the current grant.

Function
REQ-010: The block SHALL have two states. IDLE: grant_valid=0. HOLD: grant_valid=1.
REQ-011: In IDLE with any req asserted, the block SHALL select a winner and enter HOLD with grant_idx=winner on the next edge; latency from req to grant_valid is 1 cycle.
REQ-012: Winner selection SHALL be the first asserted req found scanning upward from index ptr, wrapping from REQ-1 to 0.
REQ-013: ptr SHALL be an IN-bit register; on each accept it SHALL load (grant_idx+1) mod REQ, wrapping REQ-1 to 0 even when REQ is not a power of two.
REQ-014: An accept SHALL occur in a cycle where grant_valid=1 and grant_ready=1.
REQ-015: In HOLD without an accept, grant_valid and grant_idx SHALL remain unchanged, even if the granted req bit deasserts (no retraction).
REQ-016: On an accept with any req asserted in that cycle, the block SHALL stay in HOLD and load the next winner, using the updated ptr, on the same edge; back-to-back grants give one grant per cycle.
REQ-017: On an accept with no req asserted, the block SHALL return to IDLE.
REQ-018: A req bit still asserted after its accept SHALL be eligible again only after every other asserted requester has been served once (round-robin fairness).
REQ-019: grant_ready SHALL be ignored while grant_valid=0.
REQ-020: With a single requester continuously asserted and grant_ready=1, that requester SHALL be granted every cycle.
REQ-021: req bits at index REQ or above SHALL not exist, and grant_idx SHALL never exceed REQ-1.

Reset
REQ-022: While reset=1, the block SHALL asynchronously force state=IDLE, grant_valid=0, grant_idx=0 and ptr=0.
REQ-023: If reset asserts in HOLD, the pending grant SHALL be dropped without an accept.
REQ-024: After reset deasserts, the first grant SHALL follow REQ-011 with ptr=0.

Verification
REQ-025: Reset test: assert reset mid-HOLD with grant_idx=5 -> grant_valid=0 and grant_idx=0 immediately. Release reset with req=8'h22 -> grant_idx=1 one cycle later.
REQ-026: Rotation test: IN=3, ACT=HIGH, req=8'hFF and grant_ready=1 held -> grant_idx sequence 0,1,2,...,7,0 with one grant per cycle.
REQ-027: Hold test: req=8'h10, grant_ready=0 for 4 cycles with req dropped after cycle 1 -> grant_valid=1 and grant_idx=4 stable. Then raise grant_ready -> accept, then IDLE.
REQ-028: Fairness test: req=8'h81, grant_ready=1 -> grants alternate 0,7,0,7. Requester 0 is never granted twice in a row.
REQ-029: Non-power-of-two test: REQ=5, all req asserted -> grant_idx sequence 0,1,2,3,4,0, and grant_idx never equals 5 to 7.
REQ-030: Decoder chain test: feed grant_idx into the binary decoder -> the decoded output is one-hot at the granted bit whenever grant_valid=1.
